// File: rtl/fp32_mult_pkg.sv
// Shared constants, operand class encoding and exponent helper for the FP32
// multiplier sign/exponent/packing stage.
package fp32_mult_pkg;

  localparam int          BIAS_DEF = 127;
  localparam int          EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  localparam int FLAG_INVALID   = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  typedef enum logic [1:0] {
    CLS_ZERO = 2'd0,
    CLS_NORM = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_e;

  // Biased exponent of the product; 10-bit signed so both overflow and underflow are visible.
  function automatic logic signed [9:0] calc_exp_sum(input logic [7:0] ea,
                                                     input logic [7:0] eb,
                                                     input logic       norm,
                                                     input logic [9:0] bias);
    return $signed({2'b00, ea} + {2'b00, eb} - bias + {9'd0, norm});
  endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational single-operand FP32 classifier; denormals are reported as ZERO.
module fp32_classify
  import fp32_mult_pkg::*;
(
  input  logic [31:0] operand,
  output fp_class_e   op_class
);

  logic [7:0]  exp_s;
  logic [22:0] frac_s;

  assign exp_s  = operand[30:23];
  assign frac_s = operand[22:0];

  // Decode exponent/fraction into an operand class.
  always_comb begin
    op_class = CLS_NORM;
    if (exp_s == 8'd0) begin
      op_class = CLS_ZERO;
    end else if (exp_s == 8'hFF) begin
      if (frac_s == 23'd0) begin
        op_class = CLS_INF;
      end else begin
        op_class = CLS_NAN;
      end
    end else begin
      op_class = CLS_NORM;
    end
  end

endmodule

// File: rtl/fp32_mult_pack.sv
// Two-stage valid/ready pipeline: classify and sum exponents, then resolve
// special cases and pack the FP32 result with per-beat and sticky flags.
module fp32_mult_pack
  import fp32_mult_pkg::*;
#(
  parameter int BIAS = BIAS_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  input  logic        normalised,
  input  logic [22:0] product_mantissa,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  res_flags,
  output logic [2:0]  sticky_flags,
  input  logic        flags_clr
);

  localparam logic [9:0] BIAS_W = BIAS[9:0];

  fp_class_e          cls_a_s;
  fp_class_e          cls_b_s;
  logic               s1_load_s;
  logic               s2_load_s;
  logic [31:0]        res_next_s;
  logic [2:0]         flags_next_s;

  logic               s1_valid_r;
  logic               s1_sign_r;
  fp_class_e          s1_cls_a_r;
  fp_class_e          s1_cls_b_r;
  logic signed [9:0]  s1_exp_sum_r;
  logic [22:0]        s1_mant_r;
  logic               s2_valid_r;
  logic [31:0]        result_r;
  logic [2:0]         flags_r;
  logic [2:0]         sticky_r;

  fp32_classify u_class_a (.operand(a_operand), .op_class(cls_a_s));
  fp32_classify u_class_b (.operand(b_operand), .op_class(cls_b_s));

  assign s2_load_s = !s2_valid_r || out_ready;
  assign s1_load_s = !s1_valid_r || s2_load_s;
  assign in_ready  = s1_load_s;

  // Stage 1: capture sign, operand classes, exponent sum and mantissa on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r   <= 1'b0;
      s1_sign_r    <= 1'b0;
      s1_cls_a_r   <= CLS_ZERO;
      s1_cls_b_r   <= CLS_ZERO;
      s1_exp_sum_r <= 10'sd0;
      s1_mant_r    <= 23'd0;
    end else if (s1_load_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_sign_r    <= a_operand[31] ^ b_operand[31];
        s1_cls_a_r   <= cls_a_s;
        s1_cls_b_r   <= cls_b_s;
        s1_exp_sum_r <= calc_exp_sum(a_operand[30:23], b_operand[30:23], normalised, BIAS_W);
        s1_mant_r    <= product_mantissa;
      end
    end
  end

  // Priority-ordered special-case resolution and packing of the stage-1 contents.
  always_comb begin
    res_next_s   = {s1_sign_r, s1_exp_sum_r[7:0], s1_mant_r};
    flags_next_s = 3'b000;
    if (s1_cls_a_r == CLS_NAN || s1_cls_b_r == CLS_NAN ||
        (s1_cls_a_r == CLS_INF && s1_cls_b_r == CLS_ZERO) ||
        (s1_cls_a_r == CLS_ZERO && s1_cls_b_r == CLS_INF)) begin
      res_next_s                 = QNAN;
      flags_next_s[FLAG_INVALID] = 1'b1;
    end else if (s1_cls_a_r == CLS_INF || s1_cls_b_r == CLS_INF) begin
      res_next_s = {s1_sign_r, 8'hFF, 23'd0};
    end else if (s1_cls_a_r == CLS_ZERO || s1_cls_b_r == CLS_ZERO) begin
      res_next_s = {s1_sign_r, 31'd0};
    end else if (s1_exp_sum_r >= 10'sd255) begin
      res_next_s                  = {s1_sign_r, 8'hFF, 23'd0};
      flags_next_s[FLAG_OVERFLOW] = 1'b1;
    end else if (s1_exp_sum_r <= 10'sd0) begin
      res_next_s                   = {s1_sign_r, 31'd0};
      flags_next_s[FLAG_UNDERFLOW] = 1'b1;
    end else begin
      res_next_s = {s1_sign_r, s1_exp_sum_r[7:0], s1_mant_r};
    end
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      result_r   <= 32'd0;
      flags_r    <= 3'b000;
    end else if (s2_load_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        result_r <= res_next_s;
        flags_r  <= flags_next_s;
      end
    end
  end

  // Sticky flags accumulate on delivered beats; a clear wins over a coincident beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_r <= 3'b000;
    end else if (flags_clr) begin
      sticky_r <= 3'b000;
    end else if (s2_valid_r && out_ready) begin
      sticky_r <= sticky_r | flags_r;
    end else begin
      sticky_r <= sticky_r;
    end
  end

  assign out_valid    = s2_valid_r;
  assign result       = result_r;
  assign res_flags    = flags_r;
  assign sticky_flags = sticky_r;

endmodule

// File: tb/tb_fp32_mult_pack.sv
// Directed, table-driven bench for fp32_mult_pack with hand-computed expectations.
module tb_fp32_mult_pack;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        norm;
    logic [22:0] mant;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_operand = 32'd0;
  logic [31:0] b_operand = 32'd0;
  logic        normalised = 1'b0;
  logic [22:0] product_mantissa = 23'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [2:0]  res_flags;
  logic [2:0]  sticky_flags;
  logic        flags_clr = 1'b0;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [2:0]  exp_sticky = 3'b000;
  vec_t        vecs[14];
  vec_t        bp[4];

  always #5 clk = ~clk;

  fp32_mult_pack dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_operand(a_operand), .b_operand(b_operand), .normalised(normalised),
    .product_mantissa(product_mantissa), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .res_flags(res_flags), .sticky_flags(sticky_flags),
    .flags_clr(flags_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    a_operand        = v.a;
    b_operand        = v.b;
    normalised       = v.norm;
    product_mantissa = v.mant;
  endtask

  task automatic send_and_check(input vec_t v, input string name);
    int  lat;
    bit  ok;
    @(negedge clk);
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    if (!ok) check({name, "_in_ready_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, 32'd2);
    check({name, "_result"}, result, v.res);
    check({name, "_flags"}, {29'd0, res_flags}, {29'd0, v.flg});
    @(posedge clk);
    exp_sticky = exp_sticky | v.flg;
    @(negedge clk);
    check({name, "_sticky"}, {29'd0, sticky_flags}, {29'd0, exp_sticky});
  endtask

  initial begin
    vecs[0]  = '{32'h4000_0000, 32'h4040_0000, 1'b0, 23'h40_0000, 32'h40C0_0000, 3'b000};
    vecs[1]  = '{32'h7F00_0000, 32'h7F00_0000, 1'b0, 23'h00_0000, 32'h7F80_0000, 3'b010};
    vecs[2]  = '{32'h0080_0000, 32'h8080_0000, 1'b0, 23'h00_0000, 32'h8000_0000, 3'b001};
    vecs[3]  = '{32'h7F80_0000, 32'h8000_0000, 1'b0, 23'h00_0000, 32'h7FC0_0000, 3'b100};
    vecs[4]  = '{32'h7FC0_0001, 32'h3F80_0000, 1'b0, 23'h00_0000, 32'h7FC0_0000, 3'b100};
    vecs[5]  = '{32'hFF80_0000, 32'h4000_0000, 1'b0, 23'h00_0000, 32'hFF80_0000, 3'b000};
    vecs[6]  = '{32'h0000_0000, 32'hC000_0000, 1'b0, 23'h00_0000, 32'h8000_0000, 3'b000};
    vecs[7]  = '{32'h0000_0001, 32'h4000_0000, 1'b0, 23'h00_0000, 32'h0000_0000, 3'b000};
    vecs[8]  = '{32'h5F80_0000, 32'h5F80_0000, 1'b0, 23'h00_0000, 32'h7F80_0000, 3'b010};
    vecs[9]  = '{32'h5F80_0000, 32'h5F00_0000, 1'b0, 23'h12_3456, 32'h7F12_3456, 3'b000};
    vecs[10] = '{32'h1F80_0000, 32'h2000_0000, 1'b0, 23'h7F_FFFF, 32'h0000_0000, 3'b001};
    vecs[11] = '{32'h1F80_0000, 32'h2000_0000, 1'b1, 23'h7F_FFFF, 32'h00FF_FFFF, 3'b000};
    vecs[12] = '{32'h7F80_0000, 32'hFF80_0001, 1'b0, 23'h00_0000, 32'h7FC0_0000, 3'b100};
    vecs[13] = '{32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 23'h10_0000, 32'h4010_0000, 3'b000};

    // Reset state.
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_res_flags", {29'd0, res_flags}, 32'd0);
    check("rst_sticky", {29'd0, sticky_flags}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      send_and_check(vecs[i], $sformatf("vec%0d", i));
    end

    // Standalone clear.
    @(negedge clk);
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    exp_sticky = 3'b000;
    check("clr_sticky", {29'd0, sticky_flags}, 32'd0);

    // Clear coinciding with an overflow beat's handshake.
    @(negedge clk);
    drive(vecs[1]);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
    check("clrhs_valid", {31'd0, out_valid}, 32'd1);
    check("clrhs_no_hs_sticky", {29'd0, sticky_flags}, 32'd0);
    out_ready = 1'b1;
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
    check("clrhs_sticky", {29'd0, sticky_flags}, 32'd0);
    check("clrhs_drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: 4 beats, consumer stalled for cycles 0-5.
    bp[0] = vecs[0];
    bp[1] = vecs[1];
    bp[2] = vecs[13];
    bp[3] = vecs[9];
    begin
      int          sent;
      int          got;
      bit          held;
      bit          drop_seen;
      bit          acc;
      logic [31:0] held_res;
      sent = 0;
      got = 0;
      held = 1'b0;
      drop_seen = 1'b0;
      held_res = 32'd0;
      for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
        @(negedge clk);
        out_ready = (cyc >= 6);
        in_valid  = (sent < 4);
        if (sent < 4) drive(bp[sent]);
        #1;
        if (out_valid && !out_ready) begin
          if (held) check("bp_stable", result, held_res);
          held     = 1'b1;
          held_res = result;
        end
        if (sent == 2 && cyc < 6 && !drop_seen) begin
          check("bp_in_ready_drop", {31'd0, in_ready}, 32'd0);
          drop_seen = 1'b1;
        end
        if (out_valid && out_ready) begin
          check($sformatf("bp_result%0d", got), result, bp[got].res);
          check($sformatf("bp_flags%0d", got), {29'd0, res_flags}, {29'd0, bp[got].flg});
          exp_sticky = exp_sticky | bp[got].flg;
          got++;
        end
        acc = in_valid && in_ready;
        @(posedge clk);
        if (acc) sent++;
      end
      check("bp_count", got, 32'd4);
      check("bp_drop_seen", {31'd0, drop_seen}, 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_sticky", {29'd0, sticky_flags}, {29'd0, exp_sticky});

    // Reset with two beats in flight.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(vecs[k]);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("mid_out_valid_before", {31'd0, out_valid}, 32'd1);
    check("mid_sticky_before", {29'd0, sticky_flags}, {29'd0, exp_sticky});
    rst_n = 1'b0;
    #1;
    check("mid_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_sticky", {29'd0, sticky_flags}, 32'd0);
    check("mid_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_sticky = 3'b000;
    send_and_check(vecs[0], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp32_mult_pack.md
# fp32_mult_pack

Pipelined sign/exponent/special-case and packing stage for the FP32 multiplier. It sits directly downstream of the approximate mantissa multiplier. It takes the original operands plus that stage's `normalised` flag and 23-bit `product_mantissa`, and emits a packed IEEE-754 single-precision result. Transport is valid/ready with full backpressure. Sticky exception flags are maintained until cleared.

## Interface
- `BIAS`, 127, exponent bias
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  stage can accept a beat
- `a_operand`  in  32  operand A, full FP32 word
- `b_operand`  in  32  operand B, full FP32 word
- `normalised`  in  1  mantissa product ≥ 2.0, from the mantissa multiplier
- `product_mantissa`  in  23  normalised fraction from the mantissa multiplier
- `out_valid`  out  1  result beat valid
- `out_ready`  in  1  consumer accepts the result
- `result`  out  32  packed FP32 product
- `res_flags`  out  3  per-beat flags {invalid, overflow, underflow}
- `sticky_flags`  out  3  OR of `res_flags` over all delivered beats since the last clear
- `flags_clr`  in  1  synchronous clear of `sticky_flags`

## Operation
**Stage 1 (S1)** registers the following on acceptance (`in_valid && in_ready`):
- sign = `a[31]^b[31]`
- class of each operand: ZERO when exp==0, so denormals are flushed to zero; INF when exp==255 and frac==0; NAN when exp==255 and frac!=0; NORM otherwise
- `exp_sum` = `{2'b0,ea}+{2'b0,eb}-BIAS+normalised`, a 10-bit signed value
- `product_mantissa`

**Stage 2 (S2)** resolves the result, with the first matching rule winning:
- Either operand NAN, or INF×ZERO: `result` = 32'h7FC0_0000 and invalid=1.
- Either operand INF: `result` = {sign, 8'hFF, 23'h0}.
- Either operand ZERO: `result` = {sign, 31'h0}.
- `exp_sum` ≥ 255: `result` = {sign, 8'hFF, 0} and overflow=1.
- `exp_sum` ≤ 0: `result` = {sign, 31'h0} and underflow=1.
- Otherwise: `result` = {sign, exp_sum[7:0], product_mantissa}.

**Sticky flags**
- On each output handshake (`out_valid && out_ready`), `sticky_flags |= res_flags`.
- `flags_clr` takes priority: when it coincides with a handshake, the result is `sticky_flags` = 0 and that beat's flags are dropped.

## Timing
- Latency is 2 cycles from input acceptance to `out_valid`, with no bubbles when `out_ready`=1.
- Throughput is 1 beat/cycle.
- Each stage holds a valid bit. A stage loads when it is empty or its contents are moving forward that cycle.
- `in_ready` = !s1_valid || (!s2_valid || out_ready). It is combinational, with no path from `in_valid`.
- While `out_valid`=1 and `out_ready`=0, `result` and `res_flags` hold stable.
- At most 2 beats are in flight. No beat is dropped or duplicated, and order is preserved.
- Reset values: `out_valid`=0, `result`=0, `res_flags`=0, `sticky_flags`=0, `in_ready`=1 (once in reset).
- Asserting `rst_n` mid-operation discards all in-flight beats immediately.
- Inputs are sampled only on handshake and may change freely otherwise.

## Structure
- **Package `fp32_mult_pkg`** holds:
  - `BIAS_DEF`=127, `EXP_MAX`=255, `QNAN`=32'h7FC0_0000
  - the class enum {ZERO, NORM, INF, NAN}
  - flag bit indices
- **Sub-module `fp32_classify`** is a combinational single-operand classifier. It is instantiated twice, for A and B.
- The top level contains the two pipeline registers, the handshake logic and the sticky-flag register.

## Test plan
- **Normal product, 2.0×3.0:** a=0x4000_0000, b=0x4040_0000, normalised=0, mantissa=0x40_0000 → `result`=0x40C0_0000 two cycles later; flags=0.
- **Overflow:** a=b=0x7F00_0000 with normalised=0 → `result`=0x7F80_0000; `res_flags`=3'b010; `sticky_flags`=3'b010 after the handshake.
- **Underflow and sign:** a=0x0080_0000, b=0x8080_0000 → `result`=0x8000_0000; `res_flags`=3'b001.
- **Invalid:** a=0x7F80_0000 (INF), b=0x8000_0000 (−0) → `result`=0x7FC0_0000, invalid=1. Then `flags_clr` → `sticky_flags`=0 the next cycle.
- **Backpressure:** stream 4 beats with `out_ready`=0 for cycles 0–5.
  - `in_ready` drops after 2 beats are held.
  - `result` stays stable while stalled.
  - After `out_ready` rises, all 4 results appear in order, with no loss and no duplicates.
- **Reset mid-flight:** assert `rst_n`=0 with 2 beats in flight → `out_valid`=0 and `sticky_flags`=0 at once. After release, the first new beat emerges with 2-cycle latency.
